// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants and helpers for the BCD wall clock and its 74HC595
// display driver.
//   NUM_DIGITS   : number of scanned display digits (6)
//   FRAME_W      : bits shifted into the 74HC595 chain per digit (16)
//   SEG_0..SEG_9 : seven-segment codes, bit order {dp,g,f,e,d,c,b,a}
//   shiftState_t : state encoding for the 74HC595 shift FSM
//   bcdToSeg     : BCD digit -> segments a..g (dp is added by the caller)
//   digitSelect  : digit index -> active-low one-hot select byte
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int FRAME_W    = 16;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } shiftState_t;

    // Segments a..g only; the decimal point is owned by the frame builder.
    function automatic logic [6:0] bcdToSeg(input logic [3:0] bcd);
        logic [7:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = 8'h00;
        endcase
        return code[6:0];
    endfunction

    // Bits 7:6 are never selected, so they stay high for every legal index.
    function automatic logic [7:0] digitSelect(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/hc595_driver.sv
// ---------------------------------------------------------------------------
// hc595_driver
// Serialises one 16-bit frame MSB first into a 74HC595 chain and pulses the
// storage latch afterwards. Sequence: IDLE (one cycle, loads frame) ->
// SHIFT (16 bits, SCK low SCLK_DIV cycles then high SCLK_DIV cycles per bit)
// -> LATCH (RCK high SCLK_DIV cycles) -> IDLE.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : frame_i is accepted in IDLE while this is high
//   frame_i : frame to shift out, sampled only in IDLE
//   sclk_o  : 74HC595 SCK
//   rclk_o  : 74HC595 RCK
//   sdio_o  : 74HC595 SER
//   done_o  : one-cycle pulse when the last bit has been shifted, so the
//             caller can prepare the next frame before IDLE samples it
// ---------------------------------------------------------------------------
module hc595_driver
    import clock_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               sclk_o,
    output logic               rclk_o,
    output logic               sdio_o,
    output logic               done_o
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_W);
    localparam logic [DW-1:0] DIV_MAX  = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

    shiftState_t        state_q;
    logic [FRAME_W-2:0] shreg_q;
    logic [DW-1:0]      divCnt_q;
    logic [BW-1:0]      bitCnt_q;
    logic               sclk_q;
    logic               rclk_q;
    logic               sdio_q;
    logic               done_q;

    // Whole shift engine in one registered FSM. The MSB goes straight to
    // sdio on load, so shreg only keeps the bits still to be sent. New data
    // is presented on the same edge that drops SCK, so SER is always stable
    // across the following SCK rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            sclk_q   <= 1'b0;
            rclk_q   <= 1'b0;
            sdio_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    rclk_q <= 1'b0;
                    if (start_i) begin
                        shreg_q  <= frame_i[FRAME_W-2:0];
                        sdio_q   <= frame_i[FRAME_W-1];
                        divCnt_q <= '0;
                        bitCnt_q <= '0;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (divCnt_q != DIV_MAX) begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end else begin
                        divCnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bitCnt_q == LAST_BIT) begin
                                state_q <= ST_LATCH;
                                rclk_q  <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                                sdio_q   <= shreg_q[FRAME_W-2];
                                shreg_q  <= {shreg_q[FRAME_W-3:0], 1'b0};
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (divCnt_q != DIV_MAX) begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end else begin
                        divCnt_q <= '0;
                        rclk_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk_o = sclk_q;
    assign rclk_o = rclk_q;
    assign sdio_o = sdio_q;
    assign done_o = done_q;

endmodule

// File: rtl/clock.sv
// ---------------------------------------------------------------------------
// clock
// 24-hour BCD clock (HH:MM:SS) with a six-digit seven-segment display driven
// through a 74HC595 chain. A prescaler produces a one-second tick; the time
// registers advance on that tick while the display is scanned independently.
// Ports:
//   clk_in            : system clock, rising edge
//   rst_n_in          : asynchronous reset, ACTIVE-HIGH despite the name
//   sec_ge / sec_shi  : seconds units / tens (BCD)
//   min_ge / min_shi  : minutes units / tens (BCD)
//   hour_ge / hour_shi: hours units / tens (BCD)
//   rclk_out          : 74HC595 RCK
//   sclk_out          : 74HC595 SCK
//   sdio_out          : 74HC595 SER
// Build option:
//   CLOCK_DP_BLINK_EN : when defined, the decimal point on the minute-units
//                       and hour-units digits is lit during the first half
//                       of every second.
// ---------------------------------------------------------------------------
module clock
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCLK_DIV = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    output logic [3:0] sec_ge,
    output logic [3:0] sec_shi,
    output logic [3:0] min_ge,
    output logic [3:0] min_shi,
    output logic [3:0] hour_ge,
    output logic [3:0] hour_shi,
    output logic       rclk_out,
    output logic       sclk_out,
    output logic       sdio_out
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_FREQ - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);
`ifdef CLOCK_DP_BLINK_EN
    localparam logic [PW-1:0] HALF_SEC   = PW'(CLK_FREQ / 2);
`endif

    logic [PW-1:0] prescale_q;
    logic          tick;

    logic [3:0] secGe_q,   secGe_d;
    logic [3:0] secShi_q,  secShi_d;
    logic [3:0] minGe_q,   minGe_d;
    logic [3:0] minShi_q,  minShi_d;
    logic [3:0] hourGe_q,  hourGe_d;
    logic [3:0] hourShi_q, hourShi_d;

    logic [2:0]         digitIdx_q;
    logic [3:0]         curDigit;
    logic               dpBit;
    logic [FRAME_W-1:0] frameData;
    logic               hcDone;

    assign tick = (prescale_q == PRE_MAX);

    // Free-running one-second prescaler; tick is high for the single cycle
    // at the top of the count.
    always_ff @(posedge clk_in or posedge rst_n_in) begin
        if (rst_n_in) begin
            prescale_q <= '0;
        end else if (tick) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
        end
    end

    // Next-time computation as one carry chain so every digit moves on the
    // same edge, including the full 23:59:59 -> 00:00:00 rollover.
    always_comb begin
        secGe_d   = secGe_q;
        secShi_d  = secShi_q;
        minGe_d   = minGe_q;
        minShi_d  = minShi_q;
        hourGe_d  = hourGe_q;
        hourShi_d = hourShi_q;
        if (tick) begin
            if (secGe_q != 4'd9) begin
                secGe_d = secGe_q + 4'd1;
            end else begin
                secGe_d = 4'd0;
                if (secShi_q != 4'd5) begin
                    secShi_d = secShi_q + 4'd1;
                end else begin
                    secShi_d = 4'd0;
                    if (minGe_q != 4'd9) begin
                        minGe_d = minGe_q + 4'd1;
                    end else begin
                        minGe_d = 4'd0;
                        if (minShi_q != 4'd5) begin
                            minShi_d = minShi_q + 4'd1;
                        end else begin
                            minShi_d = 4'd0;
                            if (hourShi_q == 4'd2 && hourGe_q == 4'd3) begin
                                hourShi_d = 4'd0;
                                hourGe_d  = 4'd0;
                            end else if (hourGe_q == 4'd9) begin
                                hourGe_d  = 4'd0;
                                hourShi_d = hourShi_q + 4'd1;
                            end else begin
                                hourGe_d = hourGe_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Time registers drive the digit outputs directly.
    always_ff @(posedge clk_in or posedge rst_n_in) begin
        if (rst_n_in) begin
            secGe_q   <= 4'd0;
            secShi_q  <= 4'd0;
            minGe_q   <= 4'd0;
            minShi_q  <= 4'd0;
            hourGe_q  <= 4'd0;
            hourShi_q <= 4'd0;
        end else begin
            secGe_q   <= secGe_d;
            secShi_q  <= secShi_d;
            minGe_q   <= minGe_d;
            minShi_q  <= minShi_d;
            hourGe_q  <= hourGe_d;
            hourShi_q <= hourShi_d;
        end
    end

    // Scan position. It moves on as soon as the driver has shifted the last
    // bit, so the following IDLE cycle already sees the next digit's frame.
    always_ff @(posedge clk_in or posedge rst_n_in) begin
        if (rst_n_in) begin
            digitIdx_q <= 3'd0;
        end else if (hcDone) begin
            digitIdx_q <= (digitIdx_q == LAST_DIGIT) ? 3'd0 : digitIdx_q + 3'd1;
        end
    end

    // Frame for the current scan position. The driver captures it only at
    // frame start, so later ticks cannot disturb a frame in flight.
    always_comb begin
        case (digitIdx_q)
            3'd0:    curDigit = secGe_q;
            3'd1:    curDigit = secShi_q;
            3'd2:    curDigit = minGe_q;
            3'd3:    curDigit = minShi_q;
            3'd4:    curDigit = hourGe_q;
            3'd5:    curDigit = hourShi_q;
            default: curDigit = secGe_q;
        endcase
        dpBit = 1'b0;
`ifdef CLOCK_DP_BLINK_EN
        if ((digitIdx_q == 3'd2 || digitIdx_q == 3'd4) && (prescale_q < HALF_SEC)) begin
            dpBit = 1'b1;
        end
`endif
        frameData = {dpBit, bcdToSeg(curDigit), digitSelect(digitIdx_q)};
    end

    hc595_driver #(
        .SCLK_DIV (SCLK_DIV)
    ) u_hc595 (
        .clk_i   (clk_in),
        .rst_i   (rst_n_in),
        .start_i (1'b1),
        .frame_i (frameData),
        .sclk_o  (sclk_out),
        .rclk_o  (rclk_out),
        .sdio_o  (sdio_out),
        .done_o  (hcDone)
    );

    assign sec_ge   = secGe_q;
    assign sec_shi  = secShi_q;
    assign min_ge   = minGe_q;
    assign min_shi  = minShi_q;
    assign hour_ge  = hourGe_q;
    assign hour_shi = hourShi_q;

endmodule

// File: tb/tb_clock.sv
// ---------------------------------------------------------------------------
// tb_clock
// Directed bench for the clock top. dutMain (CLK_FREQ=10, SCLK_DIV=2) covers
// counting, frame contents, scan order, latch pulse and mid-frame reset.
// dutFast (CLK_FREQ=1, one tick per cycle) walks a full day to reach the
// 23:59:59 rollover in a reasonable number of cycles.
// ---------------------------------------------------------------------------
module tb_clock;

    logic clk = 1'b0;
    logic rstMain;
    logic rstFast;

    logic [3:0] mSecGe, mSecShi, mMinGe, mMinShi, mHourGe, mHourShi;
    logic       mRclk, mSclk, mSdio;
    logic [3:0] fSecGe, fSecShi, fMinGe, fMinShi, fHourGe, fHourShi;
    logic       fRclk, fSclk, fSdio;

    logic [23:0] mainTime;
    logic [23:0] fastTime;

    int numCompared   = 0;
    int numMismatched = 0;

    assign mainTime = {mHourShi, mHourGe, mMinShi, mMinGe, mSecShi, mSecGe};
    assign fastTime = {fHourShi, fHourGe, fMinShi, fMinGe, fSecShi, fSecGe};

    // 10-unit clock period; checks sample on the falling edge.
    always #5 clk = ~clk;

    clock #(
        .CLK_FREQ (10),
        .SCLK_DIV (2)
    ) dutMain (
        .clk_in   (clk),
        .rst_n_in (rstMain),
        .sec_ge   (mSecGe),
        .sec_shi  (mSecShi),
        .min_ge   (mMinGe),
        .min_shi  (mMinShi),
        .hour_ge  (mHourGe),
        .hour_shi (mHourShi),
        .rclk_out (mRclk),
        .sclk_out (mSclk),
        .sdio_out (mSdio)
    );

    clock #(
        .CLK_FREQ (1),
        .SCLK_DIV (1)
    ) dutFast (
        .clk_in   (clk),
        .rst_n_in (rstFast),
        .sec_ge   (fSecGe),
        .sec_shi  (fSecShi),
        .min_ge   (fMinGe),
        .min_shi  (fMinShi),
        .hour_ge  (fHourGe),
        .hour_shi (fHourShi),
        .rclk_out (fRclk),
        .sclk_out (fSclk),
        .sdio_out (fSdio)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the main reset on a falling edge.
    task automatic applyStimulus(input logic resetVal);
        @(negedge clk);
        rstMain = resetVal;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Collects one frame: SER at each SCK rising edge, then the RCK pulse
    // length. Returns once RCK has dropped again.
    task automatic captureFrame(output logic [15:0] data, output int edges,
                                output int rclkCycles, output logic timedOut);
        logic prevSclk;
        data       = '0;
        edges      = 0;
        rclkCycles = 0;
        timedOut   = 1'b1;
        prevSclk   = mSclk;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mSclk && !prevSclk) begin
                data = {data[14:0], mSdio};
                edges++;
            end
            if (mRclk) rclkCycles++;
            prevSclk = mSclk;
            if (!mRclk && rclkCycles > 0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic runMainTests();
        logic [15:0] data;
        int          edges;
        int          rclkCycles;
        logic        timedOut;
        logic [15:0] expFrames [7];
        logic        sawShift;

        expFrames[0] = 16'h3FFE;
        expFrames[1] = 16'h3FFD;
`ifdef CLOCK_DP_BLINK_EN
        expFrames[2] = 16'hBFFB;
`else
        expFrames[2] = 16'h3FFB;
`endif
        expFrames[3] = 16'h3FF7;
        expFrames[4] = 16'h3FEF;
        expFrames[5] = 16'h3FDF;
        expFrames[6] = 16'h3FFE;

        // Reset state
        waitCycles(2);
        checkOutput("rst_digits", {8'h0, mainTime}, 32'h0);
        checkOutput("rst_sclk", {31'h0, mSclk}, 32'h0);
        checkOutput("rst_rclk", {31'h0, mRclk}, 32'h0);
        checkOutput("rst_sdio", {31'h0, mSdio}, 32'h0);

        // Counting and minute carry
        applyStimulus(1'b0);
        waitCycles(9);
        checkOutput("sec_before_tick", {28'h0, mSecGe}, 32'h0);
        waitCycles(1);
        checkOutput("sec_first_tick", {28'h0, mSecGe}, 32'h1);
        waitCycles(580);
        checkOutput("time_000059", {8'h0, mainTime}, 32'h000059);
        waitCycles(10);
        checkOutput("time_000100", {8'h0, mainTime}, 32'h000100);

        // Fresh reset, then seven frames in a row
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        for (int k = 0; k < 7; k++) begin
            captureFrame(data, edges, rclkCycles, timedOut);
            checkOutput($sformatf("frame%0d_timeout", k), {31'h0, timedOut}, 32'h0);
            checkOutput($sformatf("frame%0d_data", k), {16'h0, data}, {16'h0, expFrames[k]});
            checkOutput($sformatf("frame%0d_edges", k), edges, 32'd16);
            if (k == 0) checkOutput("frame0_rclk_len", rclkCycles, 32'd2);
        end

        // Reset in the middle of a shift
        sawShift = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mSclk) begin
                sawShift = 1'b1;
                break;
            end
        end
        checkOutput("midshift_found", {31'h0, sawShift}, 32'h1);
        #2 rstMain = 1'b1;
        #1;
        checkOutput("midrst_digits", {8'h0, mainTime}, 32'h0);
        checkOutput("midrst_sclk", {31'h0, mSclk}, 32'h0);
        checkOutput("midrst_rclk", {31'h0, mRclk}, 32'h0);
        checkOutput("midrst_sdio", {31'h0, mSdio}, 32'h0);
        waitCycles(2);
        applyStimulus(1'b0);
        captureFrame(data, edges, rclkCycles, timedOut);
        checkOutput("restart_timeout", {31'h0, timedOut}, 32'h0);
        checkOutput("restart_data", {16'h0, data}, 32'h3FFE);
        checkOutput("restart_edges", edges, 32'd16);
        checkOutput("restart_rclk_len", rclkCycles, 32'd2);
        checkOutput("restart_time", {8'h0, mainTime}, 32'h000006);
    endtask

    task automatic runFastTests();
        waitCycles(2);
        checkOutput("fast_rst_time", {8'h0, fastTime}, 32'h0);
        checkOutput("fast_rst_ser", {29'h0, fSclk, fRclk, fSdio}, 32'h0);
        @(negedge clk);
        rstFast = 1'b0;
        waitCycles(45296);
        checkOutput("fast_123456", {8'h0, fastTime}, 32'h123456);
        waitCycles(41103);
        checkOutput("fast_235959", {8'h0, fastTime}, 32'h235959);
        waitCycles(1);
        checkOutput("fast_wrap", {8'h0, fastTime}, 32'h000000);
    endtask

    initial begin
        rstMain = 1'b0;
        rstFast = 1'b0;
        #1;
        rstMain = 1'b1;
        rstFast = 1'b1;
        $display("[TB] starting clock bench");
        fork
            runMainTests();
            runFastTests();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
